fp_convert_ctrl: RTL and testbench
==================================

Name: fp_convert_ctrl

Overview:
- Sequential controller for the 12-bit linear-to-floating-point conversion.
- Accepts a 12-bit two's-complement sample over a valid/ready handshake and takes the absolute value.
- Normalises the magnitude one shift per clock, extracts and rounds the 4-bit significand with a 3-bit exponent, and presents {S,E,F} on an output valid/ready handshake.
- Sits between the sample source and the display/consumer logic of the converter.

Parameters:
- HOLD_OUTPUT, 1: 1 = S/E/F keep the last result after the output handshake; 0 = S/E/F clear to 0 on handshake.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  D is valid.
- in_ready  out  1  block can accept D.
- D  in  12  two's-complement input sample.
- out_valid  out  1  S/E/F result valid.
- out_ready  in  1  consumer accepts the result.
- S  out  1  sign bit.
- E  out  3  exponent, 0..7.
- F  out  4  significand, 0..15.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; S=0, E=0, F=0; out_valid=0; busy=0; in_ready=1 once rst_n releases. Reset mid-conversion aborts it; no result is emitted.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch D and capture S=D[11]; go to ABS.
  - ABS: M = |D| (12 bits), Ecnt=7; go to NORM.
    - D=12'h800 sets a saturate flag; its magnitude is not representable.
  - NORM: once per clock, if M[10]==0 && Ecnt!=0, then M<=M<<1 and Ecnt<=Ecnt-1; otherwise go to ROUND.
    - Saturate flag set: skip the shift loop and go straight to ROUND.
  - ROUND: Fraw=M[10:7], r=M[6].
    - Fraw+r==16: F=8 and E=Ecnt+1.
    - If that E exceeds 7: E=7, F=15.
    - Saturate flag set: E=7, F=15.
    - Then go to DONE.
  - DONE: out_valid=1, S/E/F stable. On out_ready, go to IDLE.
    - HOLD_OUTPUT=0: S/E/F clear to 0 on the handshake.
    - out_valid falls on the cycle after the handshake.
- in_ready=0 in all states except IDLE. in_valid outside IDLE is ignored and D is not sampled. No back-to-back overlap.
- Latency: k = number of shifts (0..7). out_valid rises k+4 clocks after the accepting edge (min 4, max 11). Saturate case: 4 clocks.
- Zero input: 7 shifts, E=0, F=0, S=0.
- Ecnt=0 stop: M[6] is always 0, so no rounding at E=0.
- S for negative zero cannot occur; D=0 gives S=0.

Optional Feature:
- Macro FPCTRL_ROUND_EN.
  - Defined: rounding as above (round half up on M[6], with carry and saturation).
  - Undefined: truncate (F=M[10:7], E=Ecnt). The ROUND state still takes 1 clock, so latency is unchanged. Saturate flag still forces E=7, F=15.

Test Plan:
- D=12'h680, out_ready=1 -> S=0, E=7, F=13; out_valid 4 clocks after accept. in_ready low for the whole conversion.
- D=12'h6C0 -> S=0, E=7, F=14 (round up). Without FPCTRL_ROUND_EN -> F=13.
- D=12'hEC0 (-320) -> S=1, E=5, F=10; latency 6 clocks. D=12'h07C -> E=4, F=8 (significand carry).
- D=12'h7FF -> S=0, E=7, F=15 (carry overflow saturates). D=12'h800 -> S=1, E=7, F=15 at 4 clocks. D=12'h000 -> S=0, E=0, F=0 at 11 clocks.
- Backpressure: hold out_ready=0 for 5 clocks after out_valid -> out_valid and S/E/F stay stable. in_valid pulsed with D=12'h123 meanwhile is not accepted. Release out_ready -> IDLE, then the next sample is accepted.
- Drop rst_n during NORM of D=12'h001 -> outputs/out_valid=0 immediately. After release: in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/fp_convert_ctrl.sv
// 12-bit two's-complement to {S,E[2:0],F[3:0]} float converter, one normalise shift per clock.
// Optional macro FPCTRL_ROUND_EN: round half up on the first dropped bit; undefined = truncate.
module fp_convert_ctrl #(
    parameter bit HOLD_OUTPUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] D,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        S,
    output logic [2:0]  E,
    output logic [3:0]  F,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS   = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [11:0] r_d;
    logic [11:0] r_m;
    logic [2:0]  r_ecnt;
    logic        r_sat;
    logic        r_s;
    logic [2:0]  r_e;
    logic [3:0]  r_f;
    logic        r_out_valid;

    logic        w_accept;
    logic        w_shift;
    logic        w_hs;
    logic [2:0]  w_e;
    logic [3:0]  w_f;
    logic [3:0]  w_fraw;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_shift  = !r_sat && !r_m[10] && (r_ecnt != 3'd0);
    assign w_hs     = (r_state == DONE) && r_out_valid && out_ready;
    assign w_fraw   = r_m[10:7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = ABS;
            ABS:     w_next = NORM;
            NORM:    if (!w_shift) w_next = ROUND;
            ROUND:   w_next = DONE;
            DONE:    if (w_hs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

`ifdef FPCTRL_ROUND_EN
    logic [4:0] w_sum;
    assign w_sum = {1'b0, w_fraw} + {4'd0, r_m[6]};

    always_comb begin
        w_e = r_ecnt;
        w_f = w_sum[3:0];
        if (w_sum[4]) begin
            // significand carried out: renormalise, or saturate if E overflows
            if (r_ecnt == 3'd7) begin
                w_e = 3'd7;
                w_f = 4'd15;
            end else begin
                w_e = r_ecnt + 3'd1;
                w_f = 4'd8;
            end
        end
        if (r_sat) begin
            w_e = 3'd7;
            w_f = 4'd15;
        end
    end
`else
    always_comb begin
        w_e = r_ecnt;
        w_f = w_fraw;
        if (r_sat) begin
            w_e = 3'd7;
            w_f = 4'd15;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d         <= 12'd0;
            r_m         <= 12'd0;
            r_ecnt      <= 3'd0;
            r_sat       <= 1'b0;
            r_s         <= 1'b0;
            r_e         <= 3'd0;
            r_f         <= 4'd0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_d <= D;
                        r_s <= D[11];
                    end
                end
                ABS: begin
                    r_m    <= r_d[11] ? (~r_d + 12'd1) : r_d;
                    r_ecnt <= 3'd7;
                    r_sat  <= (r_d == 12'h800);
                end
                NORM: begin
                    if (w_shift) begin
                        r_m    <= r_m << 1;
                        r_ecnt <= r_ecnt - 3'd1;
                    end
                end
                ROUND: begin
                    r_e <= w_e;
                    r_f <= w_f;
                end
                DONE: begin
                    // result registers settle first, valid is published one clock later
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (!HOLD_OUTPUT) begin
                            r_s <= 1'b0;
                            r_e <= 3'd0;
                            r_f <= 4'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign S         = r_s;
    assign E         = r_e;
    assign F         = r_f;

endmodule

// File: tb/tb_fp_convert_ctrl.sv
// Bench for fp_convert_ctrl: directed vectors plus a cycle-level reference model checked every cycle.
module tb_fp_convert_ctrl;

    localparam bit HOLD = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] D;
    logic        out_valid;
    logic        out_ready;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    fp_convert_ctrl #(.HOLD_OUTPUT(HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference conversion from the arithmetic definition: locate the MSB,
    // scale it to bit 10 (capped at 7 shifts), then round or truncate.
    function automatic void conv(input logic [11:0] d, output int s, output int e,
                                 output int f, output int lat);
        int mag, msb, k, m, fr, r;
        s = d[11] ? 1 : 0;
        if (d == 12'h800) begin
            e = 7; f = 15; lat = 4;
            return;
        end
        mag = d[11] ? 4096 - int'(d) : int'(d);
        msb = -1;
        for (int b = 0; b <= 10; b++) if ((mag >> b) & 1) msb = b;
        k = (msb < 0) ? 7 : ((10 - msb) > 7 ? 7 : 10 - msb);
        m = mag * (1 << k);
        e = 7 - k;
        fr = (m / 128) % 16;
        r  = (m / 64) % 2;
`ifdef FPCTRL_ROUND_EN
        if (fr + r == 16) begin
            if (e == 7) begin e = 7; f = 15; end
            else begin e = e + 1; f = 8; end
        end else begin
            f = fr + r;
        end
`else
        f = fr;
`endif
        lat = k + 4;
    endfunction

    // Cycle model: 0 idle, 1 converting, 2 result valid
    int m_phase = 0;
    int m_cnt   = 0;
    int m_s = 0, m_e = 0, m_f = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_s <= 0; m_e <= 0; m_f <= 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    int s, e, f, l;
                    conv(D, s, e, f, l);
                    m_s <= s; m_e <= e; m_f <= f;
                    m_cnt <= l;
                    m_phase <= 1;
                end
                1: begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) m_phase <= 2;
                end
                default: if (out_ready) begin
                    m_phase <= 0;
                    if (!HOLD) begin m_s <= 0; m_e <= 0; m_f <= 0; end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_out_valid", out_valid, m_phase == 2);
            chk("cyc_in_ready", in_ready, m_phase == 0);
            chk("cyc_busy", busy, m_phase != 0);
            if (m_phase != 1) begin
                chk("cyc_S", S, m_s);
                chk("cyc_E", E, m_e);
                chk("cyc_F", F, m_f);
            end
        end
    end

    // Starts and ends on a falling edge; out_ready held high.
    task automatic run_one(input logic [11:0] d, input int es, input int ee,
                           input int ef, input int elat);
        int cnt;
        D = d; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            chk("busy_in_ready", in_ready, 0);
            @(negedge clk);
            cnt++;
        end
        chk($sformatf("lat_%03h", d), cnt, elat);
        chk($sformatf("S_%03h", d), S, es);
        chk($sformatf("E_%03h", d), E, ee);
        chk($sformatf("F_%03h", d), F, ef);
        @(negedge clk);
        chk($sformatf("ret_idle_%03h", d), in_ready, 1);
    endtask

    initial begin
        int s, e, f, l, cnt;
        in_valid = 1'b0; D = 12'd0; out_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_SEF", {S, E, F}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // pin the model itself
        conv(12'hEC0, s, e, f, l);
        chk("model_EC0", s * 1000 + e * 100 + f * 10 + l, 1000 + 500 + 100 + 6);
        conv(12'h000, s, e, f, l);
        chk("model_000", e * 100 + f * 10 + l, 11);
        conv(12'h800, s, e, f, l);
        chk("model_800", s * 1000 + e * 100 + f * 10 + l, 1000 + 700 + 150 + 4);

        run_one(12'h680, 0, 7, 13, 4);
`ifdef FPCTRL_ROUND_EN
        run_one(12'h6C0, 0, 7, 14, 4);
        run_one(12'h07C, 0, 4, 8, 8);
`else
        run_one(12'h6C0, 0, 7, 13, 4);
        run_one(12'h07C, 0, 3, 15, 8);
`endif
        run_one(12'hEC0, 1, 5, 10, 6);
        run_one(12'h7FF, 0, 7, 15, 4);
        run_one(12'h800, 1, 7, 15, 4);
        run_one(12'h000, 0, 0, 0, 11);

        // backpressure: result must hold, extra sample must be ignored
        D = 12'hEC0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin @(negedge clk); cnt++; end
        chk("bp_lat", cnt, 6);
        for (int i = 0; i < 5; i++) begin
            D = 12'h123;
            in_valid = (i == 1 || i == 2);
            @(negedge clk);
            chk("bp_valid_hold", out_valid, 1);
            chk("bp_SEF_hold", {S, E, F}, {1'b1, 3'd5, 4'd10});
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
`ifdef FPCTRL_ROUND_EN
        run_one(12'h07C, 0, 4, 8, 8);
`else
        run_one(12'h07C, 0, 3, 15, 8);
`endif

        // reset in the middle of normalisation
        D = 12'h001; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_SEF", {S, E, F}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("abort_no_stale", out_valid, 0);
        end
        run_one(12'h001, 0, 0, 1, 11);
        run_one(12'h680, 0, 7, 13, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
